clause_array_ld_ctrl: RTL and testbench
=======================================

Name: clause_array_ld_ctrl

Overview:
- Sequences load and readback of the clause array.
- Load: fetches clauses from an external clause memory and writes them into the array one slot at a time with one-hot write strobes. Slots beyond the requested count are cleared.
- Readback (update): reads each slot with one-hot read strobes and streams the clause and its length out over a valid/ready handshake.
- Sits between the SAT engine's top-level control and the clause array.

Parameters:
NUM_CLAUSES, 8, number of clause slots in the array
NUM_VARS, 8, variables per clause (2 bits each)
WIDTH_C_LEN, 4, clause length field width
WIDTH_CNT, 4, width of counts and indices; must hold the value NUM_CLAUSES

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start_load_i  in  1  load request pulse
load_num_i  in  WIDTH_CNT  clauses to fetch from memory
start_update_i  in  1  readback request pulse
update_num_i  in  WIDTH_CNT  slots to read back
mem_rd_o  out  1  memory read request, one-cycle pulse
mem_addr_o  out  WIDTH_CNT  memory clause index
mem_data_i  in  NUM_VARS*2  clause returned by memory
mem_len_i  in  WIDTH_C_LEN  length returned by memory
mem_valid_i  in  1  mem_data_i/mem_len_i valid
wr_o  out  NUM_CLAUSES  one-hot array write strobe
clause_o  out  NUM_VARS*2  clause to array
clause_len_o  out  WIDTH_C_LEN  length to array
rd_o  out  NUM_CLAUSES  one-hot array read strobe
clause_i  in  NUM_VARS*2  OR-combined clause from array
clause_len_i  in  WIDTH_C_LEN*NUM_CLAUSES  per-slot lengths from array
upd_valid_o  out  1  readback data valid
upd_ready_i  in  1  readback consumer ready
upd_addr_o  out  WIDTH_CNT  slot index of readback data
upd_clause_o  out  NUM_VARS*2  readback clause
upd_len_o  out  WIDTH_C_LEN  readback length
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle completion pulse

Behaviour:
- Single clock clk. rst is asynchronous, active-low.
- On reset: all outputs 0, state IDLE, idx 0, num 0. Reset mid-operation aborts without a done_o pulse.
- States: IDLE, LD_REQ, LD_WAIT, LD_WR, LD_CLR, UP_RD, UP_CAP, UP_PUSH, DONE.

IDLE:
- start_load_i=1: num=min(load_num_i, NUM_CLAUSES), idx=0. Go to LD_REQ if num>0, else LD_CLR.
- Else start_update_i=1: num=min(update_num_i, NUM_CLAUSES), idx=0. Go to UP_RD if num>0, else DONE.
- Both starts in the same cycle: load wins; the update request is dropped.
- Starts are ignored outside IDLE.

Load path:
- LD_REQ: mem_rd_o=1 and mem_addr_o=idx for exactly one cycle, then LD_WAIT.
- LD_WAIT: hold until mem_valid_i=1, with no timeout. Capture mem_data_i into clause_o and mem_len_i into clause_len_o, then LD_WR. mem_valid_i outside LD_WAIT is ignored.
- LD_WR: wr_o=1<<idx for one cycle, clause_o/clause_len_o stable. Then idx++.
  - idx+1==NUM_CLAUSES: go to DONE.
  - Else idx+1<num: go to LD_REQ.
  - Else: go to LD_CLR.
- LD_CLR: clause_o=0, clause_len_o=0, wr_o=1<<idx for one cycle, idx++. Repeat until idx reaches NUM_CLAUSES, then DONE.
- Total load: every slot 0..NUM_CLAUSES-1 is written exactly once, in ascending order.

Readback path:
- UP_RD: rd_o=1<<idx.
- UP_CAP: rd_o held at 1<<idx. At the end of UP_CAP, capture:
  - upd_clause_o=clause_i
  - upd_len_o=clause_len_i[idx*WIDTH_C_LEN +: WIDTH_C_LEN]
  - upd_addr_o=idx
  - then go to UP_PUSH.
- UP_PUSH: rd_o=0, upd_valid_o=1, data stable until upd_ready_i=1.
  - On handshake: idx++. Go to UP_RD if idx+1<num, else DONE. upd_valid_o drops next cycle.
  - upd_ready_i while upd_valid_o=0 is ignored.
- Throughput: at most one clause per 3 cycles.

Common:
- wr_o and rd_o are never both nonzero. Each is never more than one-hot.
- DONE: done_o=1 for one cycle, then IDLE. busy_o falls in the same cycle as the DONE→IDLE transition.
- idx never wraps: terminal compares use NUM_CLAUSES and num.

Test Plan:
- Load, full: start_load_i with load_num_i=8; memory returns data=16'h0001<<k, len=k+1 after a 2-cycle latency. Required:
  - wr_o = 01,02,…,80 in order, each with matching clause_o/len.
  - mem_addr_o 0..7.
  - exactly 8 mem_rd_o pulses.
  - done_o once.
- Load, partial and clear: load_num_i=3. Required:
  - 3 mem_rd_o pulses.
  - wr_o 01,02,04 carry memory data.
  - wr_o 08..80 carry clause_o=0, len=0.
  - done_o after 8 writes.
- Load, zero and clip: load_num_i=0 → no mem_rd_o, 8 clear writes, done_o. load_num_i=12 → behaves as 8.
- Readback with backpressure: array preloaded; update_num_i=4; upd_ready_i low 5 cycles per beat. Required:
  - upd_addr_o 0..3, data stable while waiting, rd_o one-hot 2 cycles per slot.
  - 4 handshakes, then done_o.
- Simultaneous starts: start_load_i and start_update_i both high → load only, no upd_valid_o. start_update_i while busy → ignored.
- Reset mid-operation: rst low during LD_WAIT of slot 2 → all outputs 0 immediately, no done_o. After release, a new load with load_num_i=1 runs cleanly from slot 0.

Source files
------------

// File: rtl/clause_array_ld_ctrl.sv
// Load/readback sequencer for the clause array: fetches clauses from clause memory into
// one-hot write slots (clearing the unused tail) and streams slots back over valid/ready.
module clause_array_ld_ctrl #(
    parameter int unsigned NUM_CLAUSES = 8,
    parameter int unsigned NUM_VARS    = 8,
    parameter int unsigned WIDTH_C_LEN = 4,
    parameter int unsigned WIDTH_CNT   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_load_i,
    input  logic [WIDTH_CNT-1:0]               load_num_i,
    input  logic                               start_update_i,
    input  logic [WIDTH_CNT-1:0]               update_num_i,
    output logic                               mem_rd_o,
    output logic [WIDTH_CNT-1:0]               mem_addr_o,
    input  logic [NUM_VARS*2-1:0]              mem_data_i,
    input  logic [WIDTH_C_LEN-1:0]             mem_len_i,
    input  logic                               mem_valid_i,
    output logic [NUM_CLAUSES-1:0]             wr_o,
    output logic [NUM_VARS*2-1:0]              clause_o,
    output logic [WIDTH_C_LEN-1:0]             clause_len_o,
    output logic [NUM_CLAUSES-1:0]             rd_o,
    input  logic [NUM_VARS*2-1:0]              clause_i,
    input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
    output logic                               upd_valid_o,
    input  logic                               upd_ready_i,
    output logic [WIDTH_CNT-1:0]               upd_addr_o,
    output logic [NUM_VARS*2-1:0]              upd_clause_o,
    output logic [WIDTH_C_LEN-1:0]             upd_len_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam logic [WIDTH_CNT-1:0] MAX_CNT = WIDTH_CNT'(NUM_CLAUSES);

    typedef enum logic [3:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        LD_WR,
        LD_CLR,
        UP_RD,
        UP_CAP,
        UP_PUSH,
        DONE
    } state_t;

    state_t               state;
    logic [WIDTH_CNT-1:0] idx;
    logic [WIDTH_CNT-1:0] num;
    logic [WIDTH_CNT-1:0] idx_inc;
    logic [WIDTH_CNT-1:0] load_num_clip;
    logic [WIDTH_CNT-1:0] update_num_clip;
    logic [WIDTH_C_LEN-1:0] len_sel;

    function automatic logic [NUM_CLAUSES-1:0] onehot(input logic [WIDTH_CNT-1:0] i);
        return NUM_CLAUSES'(1) << i;
    endfunction

    // Request clipping, index increment and per-slot length select
    always_comb begin
        idx_inc         = idx + WIDTH_CNT'(1);
        load_num_clip   = (load_num_i > MAX_CNT) ? MAX_CNT : load_num_i;
        update_num_clip = (update_num_i > MAX_CNT) ? MAX_CNT : update_num_i;
        len_sel         = '0;
        for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
            if (idx == WIDTH_CNT'(i)) begin
                len_sel = clause_len_i[i*WIDTH_C_LEN +: WIDTH_C_LEN];
            end
        end
    end

    // Sequencer; every output is set on the transition into the state that owns it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            idx          <= '0;
            num          <= '0;
            mem_rd_o     <= 1'b0;
            mem_addr_o   <= '0;
            wr_o         <= '0;
            clause_o     <= '0;
            clause_len_o <= '0;
            rd_o         <= '0;
            upd_valid_o  <= 1'b0;
            upd_addr_o   <= '0;
            upd_clause_o <= '0;
            upd_len_o    <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            mem_rd_o <= 1'b0;
            done_o   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_load_i) begin
                        num    <= load_num_clip;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        if (load_num_clip != '0) begin
                            state      <= LD_REQ;
                            mem_rd_o   <= 1'b1;
                            mem_addr_o <= '0;
                        end else begin
                            state        <= LD_CLR;
                            clause_o     <= '0;
                            clause_len_o <= '0;
                            wr_o         <= onehot('0);
                        end
                    end else if (start_update_i) begin
                        num    <= update_num_clip;
                        idx    <= '0;
                        busy_o <= 1'b1;
                        if (update_num_clip != '0) begin
                            state <= UP_RD;
                            rd_o  <= onehot('0);
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                LD_REQ: state <= LD_WAIT;
                LD_WAIT: begin
                    if (mem_valid_i) begin
                        clause_o     <= mem_data_i;
                        clause_len_o <= mem_len_i;
                        wr_o         <= onehot(idx);
                        state        <= LD_WR;
                    end
                end
                LD_WR: begin
                    wr_o <= '0;
                    idx  <= idx_inc;
                    if (idx_inc == MAX_CNT) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else if (idx_inc < num) begin
                        state      <= LD_REQ;
                        mem_rd_o   <= 1'b1;
                        mem_addr_o <= idx_inc;
                    end else begin
                        state        <= LD_CLR;
                        clause_o     <= '0;
                        clause_len_o <= '0;
                        wr_o         <= onehot(idx_inc);
                    end
                end
                LD_CLR: begin
                    idx <= idx_inc;
                    if (idx_inc == MAX_CNT) begin
                        wr_o   <= '0;
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        wr_o <= onehot(idx_inc);
                    end
                end
                UP_RD: state <= UP_CAP;
                UP_CAP: begin
                    upd_clause_o <= clause_i;
                    upd_len_o    <= len_sel;
                    upd_addr_o   <= idx;
                    rd_o         <= '0;
                    upd_valid_o  <= 1'b1;
                    state        <= UP_PUSH;
                end
                UP_PUSH: begin
                    if (upd_ready_i) begin
                        upd_valid_o <= 1'b0;
                        idx         <= idx_inc;
                        if (idx_inc < num) begin
                            state <= UP_RD;
                            rd_o  <= onehot(idx_inc);
                        end else begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_array_ld_ctrl.sv
// Scoreboard bench for clause_array_ld_ctrl: clause memory and clause array models,
// expected writes/reads queued at stimulus time and compared as the DUT produces them.
module tb_clause_array_ld_ctrl;

    localparam int unsigned NC = 8;
    localparam int unsigned NV = 8;
    localparam int unsigned WL = 4;
    localparam int unsigned WC = 4;
    localparam int unsigned WD = NV * 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_load_i;
    logic [WC-1:0]    load_num_i;
    logic             start_update_i;
    logic [WC-1:0]    update_num_i;
    logic             mem_rd_o;
    logic [WC-1:0]    mem_addr_o;
    logic [WD-1:0]    mem_data_i;
    logic [WL-1:0]    mem_len_i;
    logic             mem_valid_i;
    logic [NC-1:0]    wr_o;
    logic [WD-1:0]    clause_o;
    logic [WL-1:0]    clause_len_o;
    logic [NC-1:0]    rd_o;
    logic [WD-1:0]    clause_i;
    logic [WL*NC-1:0] clause_len_i;
    logic             upd_valid_o;
    logic             upd_ready_i;
    logic [WC-1:0]    upd_addr_o;
    logic [WD-1:0]    upd_clause_o;
    logic [WL-1:0]    upd_len_o;
    logic             busy_o;
    logic             done_o;

    clause_array_ld_ctrl #(
        .NUM_CLAUSES(NC), .NUM_VARS(NV), .WIDTH_C_LEN(WL), .WIDTH_CNT(WC)
    ) dut (
        .clk(clk), .rst(rst),
        .start_load_i(start_load_i), .load_num_i(load_num_i),
        .start_update_i(start_update_i), .update_num_i(update_num_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .mem_len_i(mem_len_i), .mem_valid_i(mem_valid_i),
        .wr_o(wr_o), .clause_o(clause_o), .clause_len_o(clause_len_o),
        .rd_o(rd_o), .clause_i(clause_i), .clause_len_i(clause_len_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_addr_o(upd_addr_o),
        .upd_clause_o(upd_clause_o), .upd_len_o(upd_len_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NC-1:0] strobe;
        logic [WD-1:0] clause;
        logic [WL-1:0] len;
    } wr_exp_t;

    typedef struct packed {
        logic [WC-1:0] addr;
        logic [WD-1:0] clause;
        logic [WL-1:0] len;
    } upd_exp_t;

    wr_exp_t       exp_wr[$];
    logic [WC-1:0] exp_addr[$];
    upd_exp_t      exp_upd[$];

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int upd_seen = 0;
    int rd_cnt   = 0;
    int stall    = 0;
    int mem_cnt  = 0;
    logic          hold_en   = 1'b0;
    logic          hold_seen = 1'b0;
    logic [WC-1:0] mem_a     = '0;
    logic [WD-1:0] arr     [NC];
    logic [WL-1:0] arr_len [NC];
    wr_exp_t  we;
    upd_exp_t ue;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Clause array model: OR of read-selected slots, flat per-slot lengths
    always_comb begin
        clause_i     = '0;
        clause_len_i = '0;
        for (int i = 0; i < NC; i++) begin
            if (rd_o[i]) clause_i = clause_i | arr[i];
            clause_len_i[i*WL +: WL] = arr_len[i];
        end
    end

    // Write-side monitor, array update and done tracking
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NC; i++) begin
                if (n_checks == 0) begin
                    arr[i]     = '0;
                    arr_len[i] = '0;
                end
            end
        end else begin
            if (wr_o != '0 || rd_o != '0)
                check("wr_rd_excl", 64'(wr_o != '0 && rd_o != '0), 64'(0));
            if (wr_o != '0) begin
                check("wr_onehot", 64'($onehot(wr_o)), 64'(1));
                for (int i = 0; i < NC; i++) begin
                    if (wr_o[i]) begin
                        arr[i]     = clause_o;
                        arr_len[i] = clause_len_o;
                    end
                end
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 64'(wr_o), 64'(0));
                end else begin
                    we = exp_wr.pop_front();
                    check("wr_strobe", 64'(wr_o), 64'(we.strobe));
                    check("wr_clause", 64'(clause_o), 64'(we.clause));
                    check("wr_len", 64'(clause_len_o), 64'(we.len));
                end
            end
            if (done_o) begin
                done_cnt++;
                check("busy_in_done", 64'(busy_o), 64'(1));
            end
        end
    end

    // Clause memory model: answers each read two cycles later
    always @(negedge clk) begin
        if (!rst) begin
            mem_valid_i = 1'b0;
            mem_cnt     = 0;
        end else begin
            mem_valid_i = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_valid_i = 1'b1;
                    mem_data_i  = WD'(1) << mem_a;
                    mem_len_i   = WL'(mem_a) + WL'(1);
                end
            end
            if (mem_rd_o) begin
                mem_a = mem_addr_o;
                if (exp_addr.size() == 0) check("mem_rd_unexpected", 64'(1), 64'(0));
                else check("mem_addr", 64'(mem_addr_o), 64'(exp_addr.pop_front()));
                if (hold_en && mem_addr_o == WC'(2)) hold_seen = 1'b1;
                else mem_cnt = 2;
            end
        end
    end

    // Readback consumer: holds ready low for 5 valid cycles per beat
    always @(negedge clk) begin
        if (!rst) begin
            upd_ready_i = 1'b0;
            stall       = 0;
            rd_cnt      = 0;
        end else begin
            if (rd_o != '0) begin
                rd_cnt++;
                check("rd_onehot", 64'($onehot(rd_o)), 64'(1));
                if (exp_upd.size() != 0)
                    check("rd_slot", 64'(rd_o), 64'(NC'(1) << exp_upd[0].addr));
            end
            if (upd_valid_o) begin
                upd_seen++;
                if (exp_upd.size() == 0) begin
                    check("upd_unexpected", 64'(1), 64'(0));
                end else begin
                    ue = exp_upd[0];
                    check("upd_addr", 64'(upd_addr_o), 64'(ue.addr));
                    check("upd_clause", 64'(upd_clause_o), 64'(ue.clause));
                    check("upd_len", 64'(upd_len_o), 64'(ue.len));
                    stall++;
                    if (stall > 5) begin
                        upd_ready_i = 1'b1;
                        void'(exp_upd.pop_front());
                        check("rd_cycles", 64'(rd_cnt), 64'(2));
                        rd_cnt = 0;
                        stall  = 0;
                    end
                end
            end else begin
                upd_ready_i = 1'b0;
            end
        end
    end

    task automatic push_load(input int n);
        int nc;
        wr_exp_t e;
        nc = (n > NC) ? NC : n;
        for (int k = 0; k < NC; k++) begin
            e.strobe = NC'(1) << k;
            if (k < nc) begin
                e.clause = WD'(1) << k;
                e.len    = WL'(k + 1);
                exp_addr.push_back(WC'(k));
            end else begin
                e.clause = '0;
                e.len    = '0;
            end
            exp_wr.push_back(e);
        end
    endtask

    task automatic start_op(input bit ld, input int ln, input bit up, input int un);
        @(posedge clk);
        #1;
        start_load_i   = ld;
        load_num_i     = WC'(ln);
        start_update_i = up;
        update_num_i   = WC'(un);
        @(posedge clk);
        #1;
        start_load_i   = 1'b0;
        start_update_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (done_cnt == 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_timeout"}, 64'(t < 2000), 64'(1));
        repeat (2) @(negedge clk);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'(1));
        check({tag, "_busy_idle"}, 64'(busy_o), 64'(0));
        check({tag, "_wr_left"}, 64'(exp_wr.size()), 64'(0));
        check({tag, "_addr_left"}, 64'(exp_addr.size()), 64'(0));
        check({tag, "_upd_left"}, 64'(exp_upd.size()), 64'(0));
        done_cnt = 0;
    endtask

    initial begin
        upd_exp_t u;
        rst            = 1'b0;
        start_load_i   = 1'b0;
        load_num_i     = '0;
        start_update_i = 1'b0;
        update_num_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_a", 64'({mem_rd_o, mem_addr_o, wr_o, clause_o, clause_len_o, rd_o}), 64'(0));
        check("rst_out_b", 64'({upd_valid_o, upd_addr_o, upd_clause_o, upd_len_o, busy_o, done_o}), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        push_load(8);
        start_op(1'b1, 8, 1'b0, 0);
        check("busy_after_start", 64'(busy_o), 64'(1));
        wait_done("full");

        for (int k = 0; k < 4; k++) begin
            u.addr   = WC'(k);
            u.clause = WD'(1) << k;
            u.len    = WL'(k + 1);
            exp_upd.push_back(u);
        end
        upd_seen = 0;
        start_op(1'b0, 0, 1'b1, 4);
        wait_done("upd");
        check("upd_valid_cycles", 64'(upd_seen), 64'(24));

        push_load(3);
        start_op(1'b1, 3, 1'b0, 0);
        wait_done("partial");

        push_load(0);
        start_op(1'b1, 0, 1'b0, 0);
        wait_done("zero");

        push_load(12);
        start_op(1'b1, 12, 1'b0, 0);
        wait_done("clip");

        upd_seen = 0;
        push_load(2);
        start_op(1'b1, 2, 1'b1, 4);
        repeat (4) @(negedge clk);
        start_op(1'b0, 0, 1'b1, 4);
        wait_done("simul");
        check("simul_no_upd", 64'(upd_seen), 64'(0));

        hold_en   = 1'b1;
        hold_seen = 1'b0;
        push_load(8);
        start_op(1'b1, 8, 1'b0, 0);
        for (int t = 0; t < 300 && !hold_seen; t++) @(negedge clk);
        check("hold_reached", 64'(hold_seen), 64'(1));
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_out_a", 64'({mem_rd_o, mem_addr_o, wr_o, clause_o, clause_len_o, rd_o}), 64'(0));
        check("midrst_out_b", 64'({upd_valid_o, upd_addr_o, upd_clause_o, upd_len_o, busy_o, done_o}), 64'(0));
        check("midrst_wr_left", 64'(exp_wr.size()), 64'(6));
        exp_wr.delete();
        exp_addr.delete();
        hold_en = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(0));
        rst = 1'b1;

        push_load(1);
        start_op(1'b1, 1, 1'b0, 0);
        wait_done("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
